spi_reg_bank: RTL and testbench
===============================

Name: spi_reg_bank

Overview:
- Byte-level command decoder and register bank that sits directly downstream of the SPI slave.
- Consumes each received byte and interprets SPI frames as register read/write transactions.
- Drives the 16-bit value shown on the seven-segment display.
- Supplies the reply byte the SPI slave shifts out on MISO.

Parameters:
NUM_REGS, 8, number of 8-bit register addresses; legal range 5..128.
ID_VALUE, 8'hA5, constant returned by register 0.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
frame_active  input  1  high while SPI chip select is asserted; already synchronised to clk.
rx_valid  input  1  single-cycle pulse when a complete byte is in rx_byte.
rx_byte  input  8  received byte; valid only when rx_valid=1.
tx_byte  output  8  byte the SPI slave loads for the next transfer.
display_value  output  16  {reg2, reg1}; feeds the display driver.
wr_strobe  output  1  one-cycle pulse per accepted register write.
addr_err  output  1  sticky flag: access to an address >= NUM_REGS; cleared by rst, or by writing reg 3 bit7=1.

Behaviour:
- Register map:
  - 0 ID: read-only, returns ID_VALUE.
  - 1 DISP_LO: RW.
  - 2 DISP_HI: RW.
  - 3 CTRL: RW; bit7 is write-1-to-clear for addr_err, self-clears and always reads 0.
  - 4 WR_COUNT: read-only; counts accepted writes, 8-bit, wraps 8'hFF->8'h00.
  - 5..NUM_REGS-1: RW scratch.
- Reset: all RW registers=0, WR_COUNT=0, tx_byte=8'h00, wr_strobe=0, addr_err=0, state=IDLE.
- Frame format:
  - First byte is the command: bit7 is 1=read, 0=write; bits6:0 are the start address.
  - Each subsequent byte is a data slot; the address auto-increments after every data slot.
  - Address wraps from NUM_REGS-1 to 0.
  - The address counter is 7 bits; addresses >= NUM_REGS wrap only on 7-bit overflow.
- States:
  - IDLE: waits for frame_active=1, then goes to CMD.
  - CMD: on rx_valid, latches address and direction. A read goes to RD; a write goes to WR.
  - WR: on rx_valid, writes rx_byte to addr (if writable and in range), then increments addr.
  - RD: on rx_valid, increments addr (the byte clocked in is ignored).
  - Any state: frame_active=0 returns to IDLE on the next edge.
- tx_byte:
  - Registered; updated on the cycle after the rx_valid that triggers it (1-cycle latency).
  - In CMD with a read command: tx_byte <= reg[addr].
  - In RD: tx_byte <= reg[addr+1].
  - In IDLE, write frames, and for out-of-range addresses: tx_byte <= 8'h00.
  - Readback value reflects register contents at the rx_valid cycle.
- Writes:
  - Writes to regs 0 and 4 are ignored: no wr_strobe, no count.
  - Out-of-range write: ignored, sets addr_err.
  - Out-of-range read: returns 8'h00, sets addr_err.
  - Accepted write: wr_strobe=1 for exactly one cycle, registered (the cycle after rx_valid); WR_COUNT increments in the same cycle.
- display_value updates the cycle after the DISP_LO/DISP_HI write.
- Simultaneous rx_valid and frame_active=0: the byte is processed first, then state goes to IDLE.
- Frame ending in CMD before any byte: no side effects.
- rx_valid while IDLE (frame_active=0): ignored.
- rst asserted mid-frame: everything returns to reset values on that edge. Remaining bytes of that frame are ignored until frame_active drops and rises again; IDLE only leaves on a 0->1 frame_active edge.
- Registers are not otherwise cleared by a frame boundary.

Test Plan:
- Reset, then frame {8'h00} read of reg 0 (command 8'h80, one dummy byte) -> tx_byte=8'hA5 one cycle after the command rx_valid; addr_err=0.
- Write frame {8'h01, 8'h34, 8'h12} -> display_value=16'h1234; two wr_strobe pulses; then a read of reg 4 returns 8'h02.
- Burst write starting at addr 7 with 2 bytes {8'h07, 8'hAA, 8'hBB} (NUM_REGS=8) -> reg7=8'hAA, wrap to reg0 ignored; one wr_strobe; WR_COUNT +1.
- Read at addr 8'h8A (addr 10) -> tx_byte=8'h00, addr_err=1; then write {8'h03, 8'h80} -> addr_err=0, reg3 reads 8'h00.
- frame_active drops after the command byte of write frame {8'h05}, then a new frame {8'h05, 8'h5A} -> reg5=8'h5A with no spurious write from the first frame.
- rst pulsed between data bytes of {8'h01, 8'h11, <rst>, 8'h22} -> display_value=16'h0000; the byte 8'h22 does not write.

Source files
------------

// File: rtl/spi_reg_bank.sv
// spi_reg_bank
//   Byte-level command decoder and register bank placed after an SPI slave.
//   Every SPI frame is one register transaction. The first byte is the command:
//   bit7 = 1 means read, 0 means write, and bits6:0 give the start address.
//   Each byte after that is one data slot, and the address auto-increments after
//   each slot.
//
//   Register map:
//     0 ID (RO, ID_VALUE)
//     1 DISP_LO (RW)
//     2 DISP_HI (RW)
//     3 CTRL (RW, bit7 = write-1-to-clear addr_err, reads 0)
//     4 WR_COUNT (RO)
//     5..NUM_REGS-1 scratch (RW)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   frame_active  in   SPI chip select asserted (already synchronised)
//   rx_valid      in   one-cycle pulse, rx_byte holds a complete byte
//   rx_byte  [7:0]  in   received byte
//   tx_byte  [7:0]  out  reply byte for the next transfer (registered)
//   display_value [15:0] out  {DISP_HI, DISP_LO}
//   wr_strobe     out  one-cycle pulse per accepted register write
//   addr_err      out  sticky out-of-range access flag
//
// Handshake: a byte is consumed on any clock edge where rx_valid=1. No back-pressure
// exists, and every response (tx_byte, wr_strobe, register update) is visible from
// the following cycle onward.
module spi_reg_bank #(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  tx_byte,
  output logic [15:0] display_value,
  output logic        wr_strobe,
  output logic        addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR, S_RD} state_t;

  localparam int         AW         = $clog2(NUM_REGS);
  localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);
  localparam logic [6:0] LAST_ADDR  = 7'(NUM_REGS - 1);

  state_t     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] tx_q, tx_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       addr_err_q, addr_err_d;
  // Previous frame_active sample. It is used to detect the 0->1 edge that
  // starts a frame. Reset forces it high so that a frame already in progress
  // during reset stays ignored until chip select drops again.
  logic       fa_prev_q;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NUM_REGS_L;
  endfunction

  // Wraps at NUM_REGS-1. Addresses beyond the map wrap only on 7-bit overflow.
  function automatic logic [6:0] next_addr(input logic [6:0] a);
    return (a == LAST_ADDR) ? 7'd0 : a + 7'd1;
  endfunction

  function automatic logic [7:0] read_val(input logic [6:0] a);
    logic [7:0] v;
    if (!in_range(a))    v = 8'h00;
    else if (a == 7'd0)  v = ID_VALUE;
    else if (a == 7'd4)  v = wr_cnt_q;
    else                 v = regs_q[a[AW-1:0]];
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_cnt_d    = wr_cnt_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    addr_err_d  = addr_err_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 8'h00;
        if (frame_active && !fa_prev_q) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          addr_d = rx_byte[6:0];
          if (rx_byte[7]) begin
            state_d = S_RD;
            tx_d    = read_val(rx_byte[6:0]);
            if (!in_range(rx_byte[6:0])) addr_err_d = 1'b1;
          end else begin
            state_d = S_WR;
            tx_d    = 8'h00;
          end
        end
      end
      S_WR: begin
        if (rx_valid) begin
          tx_d   = 8'h00;
          addr_d = next_addr(addr_q);
          if (!in_range(addr_q)) begin
            addr_err_d = 1'b1;
          end else if (addr_q != 7'd0 && addr_q != 7'd4) begin
            wr_strobe_d = 1'b1;
            wr_cnt_d    = wr_cnt_q + 8'd1;
            if (addr_q == 7'd3) begin
              // CTRL bit7 is an action bit and is never stored.
              regs_d[addr_q[AW-1:0]] = {1'b0, rx_byte[6:0]};
              if (rx_byte[7]) addr_err_d = 1'b0;
            end else begin
              regs_d[addr_q[AW-1:0]] = rx_byte;
            end
          end
        end
      end
      S_RD: begin
        if (rx_valid) begin
          addr_d = next_addr(addr_q);
          tx_d   = read_val(next_addr(addr_q));
          if (!in_range(next_addr(addr_q))) addr_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte that arrives on the same edge as chip-select release is processed
    // above first. After that, the frame ends.
    if (!frame_active) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 7'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      wr_cnt_q    <= 8'h00;
      tx_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      addr_err_q  <= 1'b0;
      fa_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_cnt_q    <= wr_cnt_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      addr_err_q  <= addr_err_d;
      fa_prev_q   <= frame_active;
    end
  end

  assign tx_byte       = tx_q;
  assign display_value = {regs_q[2], regs_q[1]};
  assign wr_strobe     = wr_strobe_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank with NUM_REGS=8. It runs a table of frames
// whose expected values were worked out by hand. After the table, it runs
// hand-written sequences for frame aborts, mid-frame reset, chip-select release
// in the same cycle as a byte, and bytes received while idle.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_active;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [15:0] display_value;
  logic        wr_strobe;
  logic        addr_err;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;

  spi_reg_bank #(.NUM_REGS(8), .ID_VALUE(8'hA5)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_active  (frame_active),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .tx_byte       (tx_byte),
    .display_value (display_value),
    .wr_strobe     (wr_strobe),
    .addr_err      (addr_err)
  );

  // Clock and reset
  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe) strobe_cnt++;

  typedef struct {
    logic [7:0]  cmd;
    int          n;
    logic [7:0]  d [3];
    logic [7:0]  exp_tx_cmd;
    logic [7:0]  exp_tx_last;
    logic [15:0] exp_disp;
    logic        exp_err;
    int          exp_strobes;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, and the DUT samples them
  // on the next rising edge.
  task automatic send_byte(input logic [7:0] b, input logic drop);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    if (drop) frame_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk);
    frame_active = 1'b1;
  endtask

  task automatic frame_end();
    @(negedge clk);
    frame_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_one(input string name, input logic [7:0] cmd, input logic [7:0] exp);
    frame_start();
    send_byte(cmd, 1'b0);
    check(name, {24'h0, tx_byte}, {24'h0, exp});
    frame_end();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int s0;
    s0 = strobe_cnt;
    frame_start();
    send_byte(v.cmd, 1'b0);
    check($sformatf("v%0d tx_cmd", idx), {24'h0, tx_byte}, {24'h0, v.exp_tx_cmd});
    for (int i = 0; i < v.n; i++) send_byte(v.d[i], 1'b0);
    check($sformatf("v%0d tx_last", idx), {24'h0, tx_byte}, {24'h0, v.exp_tx_last});
    frame_end();
    check($sformatf("v%0d display", idx), {16'h0, display_value}, {16'h0, v.exp_disp});
    check($sformatf("v%0d addr_err", idx), {31'h0, addr_err}, {31'h0, v.exp_err});
    check($sformatf("v%0d strobes", idx), 32'(strobe_cnt - s0), 32'(v.exp_strobes));
  endtask

  initial begin
    int s0;
    //          cmd    n  data                       txc    txl    disp      err  strobes
    vecs[0]  = '{8'h80, 1, '{8'h00, 8'h00, 8'h00}, 8'hA5, 8'h00, 16'h0000, 1'b0, 0}; // ID read
    vecs[1]  = '{8'h01, 2, '{8'h34, 8'h12, 8'h00}, 8'h00, 8'h00, 16'h1234, 1'b0, 2}; // display write
    vecs[2]  = '{8'h84, 1, '{8'h00, 8'h00, 8'h00}, 8'h02, 8'h00, 16'h1234, 1'b0, 0}; // WR_COUNT=2
    vecs[3]  = '{8'h07, 2, '{8'hAA, 8'hBB, 8'h00}, 8'h00, 8'h00, 16'h1234, 1'b0, 1}; // wrap to reg0 ignored
    vecs[4]  = '{8'h87, 2, '{8'h00, 8'h00, 8'h00}, 8'hAA, 8'h34, 16'h1234, 1'b0, 0}; // read wrap 7->0->1
    vecs[5]  = '{8'h8A, 0, '{8'h00, 8'h00, 8'h00}, 8'h00, 8'h00, 16'h1234, 1'b1, 0}; // out-of-range read
    vecs[6]  = '{8'h03, 1, '{8'h80, 8'h00, 8'h00}, 8'h00, 8'h00, 16'h1234, 1'b0, 1}; // clear addr_err
    vecs[7]  = '{8'h83, 1, '{8'h00, 8'h00, 8'h00}, 8'h00, 8'h04, 16'h1234, 1'b0, 0}; // CTRL reads 0, count 4
    vecs[8]  = '{8'h03, 1, '{8'h7F, 8'h00, 8'h00}, 8'h00, 8'h00, 16'h1234, 1'b0, 1};
    vecs[9]  = '{8'h83, 0, '{8'h00, 8'h00, 8'h00}, 8'h7F, 8'h7F, 16'h1234, 1'b0, 0};
    vecs[10] = '{8'h82, 2, '{8'h00, 8'h00, 8'h00}, 8'h12, 8'h05, 16'h1234, 1'b0, 0};
    vecs[11] = '{8'h7E, 3, '{8'h11, 8'h22, 8'h33}, 8'h00, 8'h00, 16'h1234, 1'b1, 0}; // 7E,7F oor, 7-bit wrap to 0
    vecs[12] = '{8'h03, 1, '{8'h80, 8'h00, 8'h00}, 8'h00, 8'h00, 16'h1234, 1'b0, 1};
    vecs[13] = '{8'hFF, 1, '{8'h00, 8'h00, 8'h00}, 8'h00, 8'hA5, 16'h1234, 1'b1, 0}; // 7F oor then 0
    vecs[14] = '{8'h03, 1, '{8'h80, 8'h00, 8'h00}, 8'h00, 8'h00, 16'h1234, 1'b0, 1};
    vecs[15] = '{8'h84, 0, '{8'h00, 8'h00, 8'h00}, 8'h07, 8'h07, 16'h1234, 1'b0, 0};

    rst = 1'b1; frame_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset tx_byte", {24'h0, tx_byte}, 32'h0);
    check("reset display", {16'h0, display_value}, 32'h0);
    check("reset addr_err", {31'h0, addr_err}, 32'h0);
    check("reset wr_strobe", {31'h0, wr_strobe}, 32'h0);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Write frame aborted after its command, then a real write. The write count
    // is 7 here.
    s0 = strobe_cnt;
    frame_start();
    send_byte(8'h05, 1'b0);
    frame_end();
    frame_start();
    send_byte(8'h05, 1'b0);
    send_byte(8'h5A, 1'b0);
    frame_end();
    check("abort strobes", 32'(strobe_cnt - s0), 32'd1);
    read_one("abort reg5", 8'h85, 8'h5A);
    read_one("abort count", 8'h84, 8'h08);

    // Reset in the middle of a frame. Later bytes of that frame must not write.
    frame_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    @(negedge clk);
    check("pre-rst display", {16'h0, display_value}, 32'h1211);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst display", {16'h0, display_value}, 32'h0);
    s0 = strobe_cnt;
    send_byte(8'h22, 1'b0);
    @(negedge clk);
    check("rst tail display", {16'h0, display_value}, 32'h0);
    check("rst tail strobes", 32'(strobe_cnt - s0), 32'd0);
    check("rst tail tx", {24'h0, tx_byte}, 32'h0);
    frame_end();
    read_one("rst count", 8'h84, 8'h00);

    // Chip select drops on the same edge as a data byte. The byte still writes.
    s0 = strobe_cnt;
    frame_start();
    send_byte(8'h06, 1'b0);
    send_byte(8'h77, 1'b1);
    @(negedge clk);
    check("drop strobes", 32'(strobe_cnt - s0), 32'd1);
    read_one("drop reg6", 8'h86, 8'h77);

    // A byte received while idle is ignored.
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = 8'h81;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("idle tx", {24'h0, tx_byte}, 32'h0);
    read_one("idle count", 8'h84, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
